// File: rtl/fifo_burst_reader.sv
// Burst read master for the FIFO read port: pops a requested number of words and
// forwards them through a 2-entry skid buffer onto a valid/ready stream.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  output logic                  pop,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_left
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state;
  logic [1:0]            cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] buf1_data;
  logic                  buf1_last;

  logic       xfer;
  logic       room;
  logic [1:0] occ;
  logic [1:0] cnt_n;
  logic [1:0] slot;

  // Occupancy counts the word still on its way from the FIFO as already buffered.
  always_comb begin
    xfer  = m_valid && m_ready;
    occ   = 2'(cnt + {1'b0, inflight});
    room  = (occ < 2'd2) || ((occ == 2'd2) && xfer);
    pop   = (state == BURST) && (words_left != '0) && !empty && room;
    slot  = 2'(cnt - {1'b0, xfer});
    cnt_n = cnt;
    case ({inflight, xfer})
      2'b10:   cnt_n = 2'(cnt + 2'd1);
      2'b01:   cnt_n = 2'(cnt - 2'd1);
      default: cnt_n = cnt;
    endcase
  end

  assign m_valid = (cnt != 2'd0);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
      buf1_data     <= '0;
      buf1_last     <= 1'b0;
      done          <= 1'b0;
      words_left    <= '0;
    end else begin
      done          <= 1'b0;
      inflight      <= pop;
      inflight_last <= pop && (words_left == LEN_W'(1));
      cnt           <= cnt_n;
      if (pop) words_left <= LEN_W'(words_left - LEN_W'(1));

      // Head shifts out on transfer; a captured word lands behind whatever remains.
      if (xfer) begin
        m_data    <= buf1_data;
        m_last    <= buf1_last;
        buf1_data <= '0;
        buf1_last <= 1'b0;
      end
      if (inflight) begin
        if (slot == 2'd0) begin
          m_data <= data_out;
          m_last <= inflight_last;
        end else begin
          buf1_data <= data_out;
          buf1_last <= inflight_last;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              words_left <= burst_len;
              state      <= BURST;
            end else begin
              done <= 1'b1;
            end
          end
        end
        BURST: begin
          if (pop && (words_left == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          // Finish on the edge where the final word leaves the buffer.
          if ((cnt_n == 2'd0) && !inflight) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model on the read port, scoreboard on the stream.
module tb_fifo_burst_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] burst_len;
  logic       pop;
  logic       empty;
  logic [7:0] data_out;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       done;
  logic [7:0] words_left;

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_W(8)) dut (
    .clk(clk), .reset(rst_n), .start(start), .burst_len(burst_len),
    .pop(pop), .empty(empty), .data_out(data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .words_left(words_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read FIFO model: data_out valid the cycle after pop.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int bad_pop = 0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (pop) begin
      if (empty) bad_pop <= bad_pop + 1;
      data_out <= mem[rd_ptr % 256];
      rd_ptr   <= rd_ptr + 1;
      pop_cnt  <= pop_cnt + 1;
    end
  end

  typedef struct {logic [7:0] d; logic l;} exp_t;
  exp_t exp_q[$];

  typedef struct {int len; bit rnd; int exp_pops; int exp_done;} vec_t;
  vec_t vt[4];

  int n_vec = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int last_cnt = 0;
  int done_cnt = 0;
  bit saw_busy, saw_valid;
  bit prev_v, prev_r, prev_l;
  logic [7:0] prev_d;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic l, input bit expect_it);
    exp_t e;
    mem[wr_ptr % 256] = d;
    wr_ptr++;
    if (expect_it) begin
      e.d = d;
      e.l = l;
      exp_q.push_back(e);
    end
  endtask

  // Advance one cycle; monitors the stream at the falling edge, returns 1ns after rise.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r)
        chk("hold", int'({m_valid, m_last, m_data}), int'({1'b1, prev_l, prev_d}));
      if (m_valid && m_ready) begin
        xfer_cnt++;
        if (m_last) last_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_extra_word", int'(m_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", int'(m_data), int'(e.d));
          chk("sb_last", int'(m_last), int'(e.l));
        end
      end
      if (done) done_cnt++;
      if (busy) saw_busy = 1'b1;
      if (m_valid) saw_valid = 1'b1;
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    m_ready = 1'b1;
    chk("done_within_budget", int'(done_cnt != d0), 1);
  endtask

  task automatic pulse_start(input logic [7:0] len);
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
    burst_len = 8'd0;
  endtask

  int p0, d0, x0, l0;
  logic [11:0] pop_seq, val_seq, done_seq;
  logic [7:0]  wl_seq [0:11];

  initial begin
    vt[0] = '{len: 1,  rnd: 1'b0, exp_pops: 1,  exp_done: 1};
    vt[1] = '{len: 7,  rnd: 1'b1, exp_pops: 7,  exp_done: 1};
    vt[2] = '{len: 0,  rnd: 1'b0, exp_pops: 0,  exp_done: 1};
    vt[3] = '{len: 20, rnd: 1'b1, exp_pops: 20, exp_done: 1};

    rst_n = 1'b0; start = 1'b0; burst_len = 8'd0; m_ready = 1'b1;
    tick(); tick();
    chk("reset_outputs", int'({pop, m_valid, m_last, busy, done}), 0);
    chk("reset_m_data", int'(m_data), 0);
    chk("reset_words_left", int'(words_left), 0);
    rst_n = 1'b1;
    tick();

    // Gap-free 4-word burst, cycle by cycle.
    push_word(8'hA1, 1'b0, 1'b1);
    push_word(8'hA2, 1'b0, 1'b1);
    push_word(8'hA3, 1'b0, 1'b1);
    push_word(8'hA4, 1'b1, 1'b1);
    d0 = done_cnt; l0 = last_cnt;
    pulse_start(8'd4);
    for (int c = 0; c < 12; c++) begin
      pop_seq[c]  = pop;
      val_seq[c]  = m_valid;
      done_seq[c] = done;
      wl_seq[c]   = words_left;
      tick();
    end
    chk("b4_pop_pattern", int'(pop_seq), int'(12'b0000_0000_1111));
    chk("b4_valid_pattern", int'(val_seq), int'(12'b0000_0011_1100));
    chk("b4_done_pattern", int'(done_seq), int'(12'b0000_0100_0000));
    chk("b4_words_left_first", int'(wl_seq[0]), 4);
    chk("b4_words_left_end", int'(wl_seq[4]), 0);
    chk("b4_last_count", last_cnt - l0, 1);
    chk("b4_done_count", done_cnt - d0, 1);
    chk("b4_sb_empty", exp_q.size(), 0);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < vt[i].len; k++)
        push_word(8'(8'h10 * (i + 1) + k), 1'(k == vt[i].len - 1), 1'b1);
      p0 = pop_cnt; d0 = done_cnt; l0 = last_cnt;
      saw_busy = 1'b0; saw_valid = 1'b0;
      pulse_start(8'(vt[i].len));
      wait_done(400, vt[i].rnd);
      tick(); tick(); tick();
      chk("vec_pops", pop_cnt - p0, vt[i].exp_pops);
      chk("vec_done", done_cnt - d0, vt[i].exp_done);
      chk("vec_last", last_cnt - l0, (vt[i].len != 0) ? 1 : 0);
      chk("vec_idle", int'({busy, words_left}), 0);
      chk("vec_sb_empty", exp_q.size(), 0);
      if (vt[i].len == 0) chk("len0_quiet", int'({saw_busy, saw_valid}), 0);
    end

    // Backpressure: only two pops fit while the consumer is stalled.
    push_word(8'hB1, 1'b0, 1'b1);
    push_word(8'hB2, 1'b0, 1'b1);
    push_word(8'hB3, 1'b1, 1'b1);
    m_ready = 1'b0;
    p0 = pop_cnt; d0 = done_cnt; x0 = xfer_cnt;
    pulse_start(8'd3);
    for (int c = 0; c < 9; c++) tick();
    chk("stall_pops", pop_cnt - p0, 2);
    chk("stall_head", int'({m_valid, m_data}), int'({1'b1, 8'hB1}));
    m_ready = 1'b1;
    wait_done(50, 1'b0);
    chk("stall_xfers", xfer_cnt - x0, 3);
    chk("stall_done", done_cnt - d0, 1);
    chk("stall_sb_empty", exp_q.size(), 0);

    // FIFO runs dry mid-burst and refills later.
    push_word(8'hC1, 1'b0, 1'b1);
    p0 = pop_cnt; d0 = done_cnt;
    pulse_start(8'd3);
    for (int c = 0; c < 5; c++) tick();
    chk("dry_pops_paused", pop_cnt - p0, 1);
    chk("dry_busy", int'(busy), 1);
    push_word(8'hC2, 1'b0, 1'b1);
    push_word(8'hC3, 1'b1, 1'b1);
    wait_done(50, 1'b0);
    chk("dry_pops", pop_cnt - p0, 3);
    chk("dry_done", done_cnt - d0, 1);
    chk("no_pop_when_empty", bad_pop, 0);
    chk("dry_sb_empty", exp_q.size(), 0);

    // A second start during a burst is ignored.
    push_word(8'hD1, 1'b0, 1'b1);
    push_word(8'hD2, 1'b1, 1'b1);
    p0 = pop_cnt; d0 = done_cnt;
    pulse_start(8'd2);
    tick();
    pulse_start(8'd5);
    wait_done(50, 1'b0);
    for (int c = 0; c < 6; c++) tick();
    chk("busy_start_pops", pop_cnt - p0, 2);
    chk("busy_start_done", done_cnt - d0, 1);
    chk("busy_start_idle", int'(busy), 0);
    chk("busy_start_sb_empty", exp_q.size(), 0);

    // Reset with two words buffered discards them; next burst reads on.
    push_word(8'hE1, 1'b0, 1'b0);
    push_word(8'hE2, 1'b0, 1'b0);
    push_word(8'hE3, 1'b0, 1'b0);
    push_word(8'hE4, 1'b0, 1'b0);
    m_ready = 1'b0;
    p0 = pop_cnt; d0 = done_cnt;
    pulse_start(8'd4);
    for (int c = 0; c < 4; c++) tick();
    chk("rst_pre_pops", pop_cnt - p0, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", int'({pop, m_valid, m_last, busy, done}), 0);
    chk("rst_mid_data", int'({m_data, words_left}), 0);
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("rst_no_done", done_cnt - d0, 0);
    exp_q.push_back('{d: 8'hE3, l: 1'b1});
    pulse_start(8'd1);
    wait_done(50, 1'b0);
    tick(); tick();
    chk("rst_after_sb_empty", exp_q.size(), 0);
    chk("rst_after_pops", pop_cnt - p0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
